mips_fetch: RTL and testbench
=============================

# mips_fetch

Instruction-fetch sequencer that owns the program counter and feeds `opcode`/`funct` into `mips_decode`. It closes the loop on the decoder's `control_type` and `except` outputs to select the next PC. It fetches one instruction per retirement over a req/ack instruction-memory port and presents it under a valid/ready handshake to the decode/execute stage.

## Interface
- `RESET_PC`, default 32'h0040_0000: PC loaded on reset.
- `EXC_VECTOR`, default 32'h8000_0180: PC loaded when an instruction retires with `except`=1.

Ports:
- `clock` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low. Low asserts reset immediately; release is synchronous to `clock`.
- `imem_req` out 1: fetch request; held until `imem_ack`.
- `imem_addr` out 32: byte address of fetch, always equal to `pc`.
- `imem_ack` in 1: memory returns `imem_data` this cycle.
- `imem_data` in 32: instruction word.
- `inst` out 32: held instruction.
- `opcode` out 6: `inst[31:26]`.
- `funct` out 6: `inst[5:0]`.
- `inst_valid` out 1: `inst` is valid for decode.
- `inst_ready` in 1: consumer retires `inst` this cycle.
- `control_type` in 2: from decoder. 0 = sequential, 1 = branch, 2 = jump, 3 = jr.
- `except` in 1: from decoder; the retiring instruction faults.
- `jr_target` in 32: rs value for jr.
- `pc` out 32: address of `inst`.
- `pc_plus4` out 32: `pc`+4.
- `epc` out 32: PC of the last excepting instruction.

## Operation
FSM states are BOOT, REQ and HOLD.
- **BOOT**: entered on reset. `imem_req`=0. Goes to REQ on the next clock edge.
- **REQ**: `imem_req`=1 and `imem_addr`=`pc`, both stable until ack.
  - On `imem_ack`=1: `inst`<=`imem_data`, then go to HOLD.
- **HOLD**: `inst_valid`=1, and `inst` is stable while `inst_ready`=0.
  - On `inst_ready`=1: the instruction retires. `pc`<=next PC, then go to REQ.
- `imem_ack` is ignored in BOOT and HOLD.
- `control_type` and `except` are sampled only on the retirement edge.

Next-PC selection (all arithmetic mod 2^32):
- If `except`=1: next PC is `EXC_VECTOR` and `epc`<=`pc`. `except` overrides `control_type`.
- If `control_type`=0: next PC is `pc_plus4`.
- If `control_type`=1: next PC is `pc_plus4` + (sign_extend(`inst[15:0]`) << 2).
- If `control_type`=2: next PC is {`pc_plus4[31:28]`, `inst[25:0]`, 2'b00}.
- If `control_type`=3: next PC is {`jr_target[31:2]`, 2'b00`}`. Misaligned low bits are dropped silently.

Branch handling:
- The taken/not-taken decision is already folded into `control_type` by the decoder.
- This block never reads the ALU `zero` flag.

Reset values:
- `pc`=`RESET_PC`, `inst`=0, `opcode`=0, `funct`=0, `epc`=0.
- `inst_valid`=0, `imem_req`=0, state BOOT.
- `pc_plus4`=`RESET_PC`+4.

## Timing
- Minimum cycles per instruction is 2: REQ with same-cycle ack, then HOLD with same-cycle ready.
- The first `imem_req` rises 1 cycle after reset release.
- With ack latency L cycles (L≥0 after req rises) and ready delay R cycles, one instruction takes 2+L+R cycles.
- `opcode`, `funct` and `pc_plus4` are combinational from registered `inst`/`pc`. They are valid from the first cycle of HOLD.
- Reset asserted mid-REQ:
  - Outputs go to reset values asynchronously and the outstanding request is abandoned.
  - A late ack then arrives in BOOT and is ignored.
- Reset asserted mid-HOLD: `inst_valid` drops immediately and there is no retirement.
- `pc` wraps 32'hFFFF_FFFC to 32'h0000_0000 on a sequential step.
- A backward branch below 0 also wraps.

## Structure
- Shared header (alongside the opcode defines) adds:
  - `CT_NEXT`, `CT_BRANCH`, `CT_JUMP`, `CT_JR` (values 0 to 3).
  - Default `RESET_PC` and `EXC_VECTOR` constants.
  - `mips_decode` uses the same `CT_*` encodings.
- Sub-module `mips_next_pc`: purely combinational target mux.
  - Inputs: `pc`, `inst`, `control_type`, `except`, `jr_target`.
  - Output: next PC.
  - Verified standalone.

## Test plan
- Sequential fetch with ack and ready tied high:
  - pcs 0x00400000, 0x00400004, 0x00400008.
  - `imem_req` falls only in HOLD.
  - 2 cycles per instruction.
- Ack delayed 3 cycles and ready delayed 2 cycles:
  - `imem_addr` and `inst` stay stable throughout.
  - 7 cycles per instruction.
  - An ack pulse during HOLD is ignored.
- Branch with `pc`=0x00400010, `inst[15:0]`=0xFFFF, `control_type`=1: next pc=0x00400010.
- Jump with `pc`=0x00400000, `inst[25:0]`=0x0100008, `control_type`=2: next pc=0x00400020.
- jr with `jr_target`=0x00400033: next pc=0x00400030.
- Except asserted together with `control_type`=2 at `pc`=0x00400008: next pc=0x80000180 and `epc`=0x00400008.
- Reset pulled low mid-REQ:
  - All outputs go to reset values within the same cycle.
  - A late ack in BOOT is ignored.
  - The fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/mips_fetch_pkg.sv
// Shared definitions for the fetch sequencer and the decoder that drives it.
package mips_fetch_pkg;

    // Control-type encodings, shared with mips_decode
    localparam logic [1:0] CT_NEXT   = 2'd0;
    localparam logic [1:0] CT_BRANCH = 2'd1;
    localparam logic [1:0] CT_JUMP   = 2'd2;
    localparam logic [1:0] CT_JR     = 2'd3;

    // Default boot and exception addresses
    localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0040_0000;
    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h8000_0180;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_t;

    // Sign-extended word offset of a branch immediate, in bytes
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/mips_fetch_next_pc.sv
// Combinational next-PC target mux. An exception overrides every control type.
module mips_next_pc
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
    input  logic [31:0] pc,
    input  logic [31:0] inst,
    input  logic [1:0]  control_type,
    input  logic        except,
    input  logic [31:0] jr_target,
    output logic [31:0] next_pc
);

    logic [31:0] pc_plus4;
    logic        unused_bits;

    assign pc_plus4    = pc + 32'd4;
    // Opcode field and jr low bits are not needed to form a target
    assign unused_bits = ^{inst[31:26], jr_target[1:0]};

    // Select the target for the retiring instruction
    always_comb begin
        next_pc = pc_plus4;
        if (except) begin
            next_pc = EXC_VECTOR;
        end else begin
            case (control_type)
                CT_NEXT:   next_pc = pc_plus4;
                CT_BRANCH: next_pc = pc_plus4 + branch_offset(inst[15:0]);
                CT_JUMP:   next_pc = {pc_plus4[31:28], inst[25:0], 2'b00};
                CT_JR:     next_pc = {jr_target[31:2], 2'b00};
                default:   next_pc = pc_plus4;
            endcase
        end
    end

endmodule

// File: rtl/mips_fetch.sv
// Instruction-fetch sequencer: owns the PC, fetches over req/ack and presents
// the instruction to decode/execute under valid/ready.
//
// state | meaning
// BOOT  | just out of reset, no request outstanding
// REQ   | request to imem at pc, waiting for ack
// HOLD  | instruction held valid, waiting for retirement
module mips_fetch
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [31:0] inst,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic [1:0]  control_type,
    input  logic        except,
    input  logic [31:0] jr_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] epc
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, inst_q, epc_q;
    logic [31:0]  next_pc;
    logic         fetch_done;
    logic         retire;

    mips_next_pc #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_next_pc (
        .pc           (pc_q),
        .inst         (inst_q),
        .control_type (control_type),
        .except       (except),
        .jr_target    (jr_target),
        .next_pc      (next_pc)
    );

    assign fetch_done = (state_q == ST_REQ)  && imem_ack;
    assign retire     = (state_q == ST_HOLD) && inst_ready;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and handshake outputs
    always_comb begin
        state_d    = state_q;
        imem_req   = 1'b0;
        inst_valid = 1'b0;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                inst_valid = 1'b1;
                if (inst_ready) begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // Datapath registers: capture on ack, advance pc and epc on retirement
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q   <= RESET_PC;
            inst_q <= 32'h0;
            epc_q  <= 32'h0;
        end else begin
            if (fetch_done) begin
                inst_q <= imem_data;
            end
            if (retire) begin
                pc_q <= next_pc;
                if (except) begin
                    epc_q <= pc_q;
                end
            end
        end
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign pc_plus4  = pc_q + 32'd4;
    assign inst      = inst_q;
    assign opcode    = inst_q[31:26];
    assign funct     = inst_q[5:0];
    assign epc       = epc_q;

endmodule

// File: tb/tb_mips_fetch.sv
// Directed bench for mips_fetch; the bench plays both imem and the decoder.
module tb_mips_fetch;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_data = 32'h0;
    logic [31:0] inst;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [1:0]  control_type = 2'd0;
    logic        except = 1'b0;
    logic [31:0] jr_target = 32'h0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] epc;

    int n_vec = 0;
    int n_err = 0;
    int cycle = 0;
    int t0;

    mips_fetch dut (
        .clock        (clock),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_data    (imem_data),
        .inst         (inst),
        .opcode       (opcode),
        .funct        (funct),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .control_type (control_type),
        .except       (except),
        .jr_target    (jr_target),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .epc          (epc)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle <= cycle + 1;

    initial begin
        #100000;
        $display("FAIL timeout: run did not finish (observed running, expected done)");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One instruction from REQ with same-cycle ack and same-cycle ready
    task automatic fetch(input string tag, input logic [31:0] data, input logic [1:0] ct,
                         input logic exc, input logic [31:0] jrt, input logic [31:0] exp_pc);
        imem_ack   = 1'b1;
        imem_data  = data;
        inst_ready = 1'b0;
        tick();
        check({tag, "_inst"}, inst, data);
        check({tag, "_valid"}, {31'h0, inst_valid}, 32'h1);
        imem_ack     = 1'b0;
        inst_ready   = 1'b1;
        control_type = ct;
        except       = exc;
        jr_target    = jrt;
        tick();
        check({tag, "_next_pc"}, pc, exp_pc);
        check({tag, "_req"}, {31'h0, imem_req}, 32'h1);
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_pc", pc, 32'h0040_0000);
        check("rst_pc_plus4", pc_plus4, 32'h0040_0004);
        check("rst_inst", inst, 32'h0);
        check("rst_opcode", {26'h0, opcode}, 32'h0);
        check("rst_funct", {26'h0, funct}, 32'h0);
        check("rst_epc", epc, 32'h0);
        check("rst_valid", {31'h0, inst_valid}, 32'h0);
        check("rst_req", {31'h0, imem_req}, 32'h0);

        // Sequential fetch with ack and ready tied high
        imem_ack   = 1'b1;
        inst_ready = 1'b1;
        imem_data  = 32'h2002_0005;
        reset      = 1'b1;
        tick();
        check("seq_req_first", {31'h0, imem_req}, 32'h1);
        check("seq_addr0", imem_addr, 32'h0040_0000);
        t0 = cycle;
        tick();
        check("seq_hold_valid", {31'h0, inst_valid}, 32'h1);
        check("seq_hold_req", {31'h0, imem_req}, 32'h0);
        check("seq_inst0", inst, 32'h2002_0005);
        check("seq_opcode0", {26'h0, opcode}, 32'h08);
        check("seq_funct0", {26'h0, funct}, 32'h05);
        check("seq_pc_plus4", pc_plus4, 32'h0040_0004);
        imem_data = 32'h0000_0020;
        tick();
        check("seq_pc1", pc, 32'h0040_0004);
        check("seq_cpi", cycle - t0, 2);
        check("seq_req1", {31'h0, imem_req}, 32'h1);
        tick();
        check("seq_funct1", {26'h0, funct}, 32'h20);
        tick();
        check("seq_pc2", pc, 32'h0040_0008);

        // Ack delayed 3 cycles, ready delayed 2 cycles, then except over jump
        t0 = cycle;
        imem_ack   = 1'b0;
        inst_ready = 1'b0;
        imem_data  = 32'hBAD0_0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("dly_req", {31'h0, imem_req}, 32'h1);
            check("dly_addr", imem_addr, 32'h0040_0008);
        end
        imem_ack  = 1'b1;
        imem_data = 32'h0800_0040;
        tick();
        check("dly_valid", {31'h0, inst_valid}, 32'h1);
        imem_data = 32'hDEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("dly_inst_stable", inst, 32'h0800_0040);
            check("dly_hold_req", {31'h0, imem_req}, 32'h0);
        end
        imem_ack     = 1'b0;
        inst_ready   = 1'b1;
        control_type = 2'd2;
        except       = 1'b1;
        tick();
        check("dly_cpi", cycle - t0, 7);
        check("exc_pc", pc, 32'h8000_0180);
        check("exc_epc", epc, 32'h0040_0008);

        // Reset pulled low mid-REQ
        inst_ready   = 1'b0;
        except       = 1'b0;
        control_type = 2'd0;
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_req", {31'h0, imem_req}, 32'h0);
        check("mid_rst_pc", pc, 32'h0040_0000);
        check("mid_rst_epc", epc, 32'h0);
        check("mid_rst_inst", inst, 32'h0);
        tick();
        imem_ack  = 1'b1;
        imem_data = 32'h1234_5678;
        reset     = 1'b1;
        tick();
        check("late_ack_inst", inst, 32'h0);
        check("late_ack_valid", {31'h0, inst_valid}, 32'h0);
        check("restart_req", {31'h0, imem_req}, 32'h1);
        check("restart_addr", imem_addr, 32'h0040_0000);

        // Control-flow targets
        fetch("jump", 32'h0810_0008, 2'd2, 1'b0, 32'h0, 32'h0040_0020);
        fetch("jr", 32'h03E0_0008, 2'd3, 1'b0, 32'h0040_0033, 32'h0040_0030);
        fetch("br_back", 32'h1000_FFF7, 2'd1, 1'b0, 32'h0, 32'h0040_0010);
        fetch("br_self", 32'h1000_FFFF, 2'd1, 1'b0, 32'h0, 32'h0040_0010);
        check("br_opcode", {26'h0, opcode}, 32'h04);
        fetch("jr_top", 32'h03E0_0008, 2'd3, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFC);
        fetch("seq_wrap", 32'h0000_0020, 2'd0, 1'b0, 32'h0, 32'h0000_0000);
        fetch("br_wrap", 32'h1000_FFFE, 2'd1, 1'b0, 32'h0, 32'hFFFF_FFFC);
        fetch("exc_br", 32'h1000_0004, 2'd1, 1'b1, 32'h0, 32'h8000_0180);
        check("exc_br_epc", epc, 32'hFFFF_FFFC);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
